// File: rtl/merlin_mtimer.sv
// Machine timer: 64-bit prescaled mtime, 64-bit mtimecmp and a level interrupt,
// reached through a request/response port with a one-deep response buffer.
module merlin_mtimer #(
    parameter logic [31:0] C_BASE_ADDR = 32'h00010000,
    parameter logic [15:0] C_PRESCALE  = 16'd1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        treqready_o,
    input  logic        treqvalid_i,
    input  logic        treqdvalid_i,
    input  logic [31:0] treqaddr_i,
    input  logic [31:0] treqdata_i,
    input  logic        trspready_i,
    output logic        trspvalid_o,
    output logic [31:0] trspdata_o,
    output logic        irq_timer_o
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] presc_q, presc_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic [29:0] word_off;
    logic [2:0]  word_idx;
    logic        in_window;
    logic        accept;
    logic        wr_en;
    logic        tick;
    logic [31:0] rdata;
    logic        unused_addr_lsbs;

    // Byte lane bits carry no meaning: decode on the word offset from the base.
    assign unused_addr_lsbs = ^treqaddr_i[1:0];
    assign word_off  = treqaddr_i[31:2] - C_BASE_ADDR[31:2];
    assign in_window = (word_off[29:3] == 27'd0);
    assign word_idx  = word_off[2:0];

    assign treqready_o = ~rsp_valid_q | trspready_i;
    assign accept      = treqvalid_i & treqready_o;
    assign wr_en       = accept & treqdvalid_i & in_window;
    assign tick        = en_q & (presc_q == C_PRESCALE - 16'd1);

    always_comb begin
        rdata = '0;
        if (in_window) begin
            case (word_idx)
                3'd0:    rdata = mtime_q[31:0];
                3'd1:    rdata = mtime_q[63:32];
                3'd2:    rdata = mtimecmp_q[31:0];
                3'd3:    rdata = mtimecmp_q[63:32];
                3'd4:    rdata = {30'd0, irq_en_q, en_q};
                default: rdata = '0;
            endcase
        end
    end

    always_comb begin
        mtime_d    = mtime_q + {63'd0, tick};
        presc_d    = presc_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        if (en_q) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end
        // A write to either mtime half overrides the tick, leaving the other half untouched.
        if (wr_en) begin
            case (word_idx)
                3'd0: mtime_d = {mtime_q[63:32], treqdata_i};
                3'd1: mtime_d = {treqdata_i, mtime_q[31:0]};
                3'd2: mtimecmp_d = {mtimecmp_q[63:32], treqdata_i};
                3'd3: mtimecmp_d = {treqdata_i, mtimecmp_q[31:0]};
                3'd4: begin
                    en_d     = treqdata_i[0];
                    irq_en_d = treqdata_i[1];
                    if (treqdata_i[0] != en_q) begin
                        presc_d = 16'd0;
                    end
                end
                default: ;
            endcase
        end
        irq_d = irq_en_d & (mtime_d >= mtimecmp_d);

        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = treqdvalid_i ? 32'd0 : rdata;
        end else if (trspready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            presc_q     <= '0;
            en_q        <= 1'b1;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            presc_q     <= presc_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign trspvalid_o = rsp_valid_q;
    assign trspdata_o  = rsp_data_q;
    assign irq_timer_o = irq_q;

endmodule
